// File: rtl/pipeline_stage_register.sv
// pipeline_stage_register: elastic valid/ready stage carrying a payload plus an instruction word.
// Define PIPELINE_STAGE_SKID_EN for the two-entry skid version with a registered in_ready.
module pipeline_stage_register #(
  parameter int              XLEN      = 32,
  parameter int              DATA_W    = 128,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [XLEN-1:0]   in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [XLEN-1:0]   out_instr,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic [XLEN-1:0]   main_instr_reg, main_instr_next;
  logic              accept;
  logic              consume;

  // Outputs come straight from flops; the main register is cleared whenever it empties,
  // so a bubble always shows zero payload and the NOP instruction.
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_data_reg;
  assign out_instr = main_instr_reg;
  assign occupancy = state_reg;
  assign consume   = out_valid & out_ready;
  assign accept    = in_valid & in_ready & ~flush;

`ifdef PIPELINE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;
  logic [XLEN-1:0]   skid_instr_reg, skid_instr_next;
  logic              in_ready_reg, in_ready_next;

  assign in_ready = in_ready_reg;

  always_comb begin
    state_next      = state_reg;
    main_data_next  = main_data_reg;
    main_instr_next = main_instr_reg;
    skid_data_next  = skid_data_reg;
    skid_instr_next = skid_instr_reg;

    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next      = MAIN;
          main_data_next  = in_data;
          main_instr_next = in_instr;
        end
      end
      MAIN: begin
        if (accept && consume) begin
          main_data_next  = in_data;
          main_instr_next = in_instr;
        end else if (consume) begin
          state_next      = EMPTY;
          main_data_next  = '0;
          main_instr_next = NOP_INSTR;
        end else if (accept) begin
          state_next      = SKID;
          skid_data_next  = in_data;
          skid_instr_next = in_instr;
        end
      end
      SKID: begin
        // in_ready is low here, so only the skid-to-main move can happen
        if (consume) begin
          state_next      = MAIN;
          main_data_next  = skid_data_reg;
          main_instr_next = skid_instr_reg;
          skid_data_next  = '0;
          skid_instr_next = NOP_INSTR;
        end
      end
      default: begin
        state_next      = EMPTY;
        main_data_next  = '0;
        main_instr_next = NOP_INSTR;
      end
    endcase

    if (flush) begin
      state_next      = EMPTY;
      main_data_next  = '0;
      main_instr_next = NOP_INSTR;
      skid_data_next  = '0;
      skid_instr_next = NOP_INSTR;
    end

    in_ready_next = (state_next != SKID);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= EMPTY;
      main_data_reg  <= '0;
      main_instr_reg <= NOP_INSTR;
      skid_data_reg  <= '0;
      skid_instr_reg <= NOP_INSTR;
      in_ready_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      main_data_reg  <= main_data_next;
      main_instr_reg <= main_instr_next;
      skid_data_reg  <= skid_data_next;
      skid_instr_reg <= skid_instr_next;
      in_ready_reg   <= in_ready_next;
    end
  end
`else
  // Holds in_ready low during reset and for the first edge after release.
  logic ready_en_reg;

  assign in_ready = ready_en_reg & (~out_valid | out_ready);

  always_comb begin
    state_next      = state_reg;
    main_data_next  = main_data_reg;
    main_instr_next = main_instr_reg;

    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next      = MAIN;
          main_data_next  = in_data;
          main_instr_next = in_instr;
        end
      end
      MAIN: begin
        if (accept) begin
          main_data_next  = in_data;
          main_instr_next = in_instr;
        end else if (consume) begin
          state_next      = EMPTY;
          main_data_next  = '0;
          main_instr_next = NOP_INSTR;
        end
      end
      default: begin
        state_next      = EMPTY;
        main_data_next  = '0;
        main_instr_next = NOP_INSTR;
      end
    endcase

    if (flush) begin
      state_next      = EMPTY;
      main_data_next  = '0;
      main_instr_next = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= EMPTY;
      main_data_reg  <= '0;
      main_instr_reg <= NOP_INSTR;
      ready_en_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      main_data_reg  <= main_data_next;
      main_instr_reg <= main_instr_next;
      ready_en_reg   <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Directed and randomised checks for pipeline_stage_register; expectations follow
// PIPELINE_STAGE_SKID_EN the same way the design does.
module tb_pipeline_stage_register;

  localparam int              XLEN   = 32;
  localparam int              DATA_W = 128;
  localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [XLEN-1:0]   in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [XLEN-1:0]   out_instr;
  logic [1:0]        occupancy;

  int errors = 0;
  int checks = 0;
  int q[$];

  typedef struct packed {
    logic       v;
    logic [7:0] t;
    logic       o;
    logic       f;
    logic       ev;
    logic [7:0] et;
    logic       er;
    logic [1:0] eo;
  } vec_t;

  pipeline_stage_register #(
    .XLEN(XLEN), .DATA_W(DATA_W), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_instr(out_instr),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] t);
    return {{(DATA_W-32){1'b0}}, t};
  endfunction

  function automatic logic [XLEN-1:0] mk_instr(input logic [31:0] t);
    return 32'h1000_0000 | t;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] t, input logic o, input logic f);
    in_valid  = v;
    in_data   = mk_data(t);
    in_instr  = mk_instr(t);
    out_ready = o;
    flush     = f;
  endtask

  task automatic test_reset();
    offer(1'b1, 32'h77, 1'b0, 1'b0);
    cyc();
    offer(1'b1, 32'h78, 1'b0, 1'b0);
    cyc();
    reset_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", out_data); end
    checks++;
    if (out_instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h expected %h", out_instr, NOP); end
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ: got %0d expected 0", occupancy); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b expected 0", in_ready); end
    repeat (3) cyc();
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_release: got %b expected 0", in_ready); end
    cyc();
    #2;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_after: got %b expected 0", out_valid); end
    $display("reset: released, in_ready=%b", in_ready);
    cyc();
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 17; i++) begin
      offer(i <= 16, 32'(i), 1'b1, 1'b0);
      #2;
      if (i <= 16) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready %0d: got %b expected 1", i, in_ready); end
      end
      if (i == 1) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b expected 0", out_valid); end
      end else begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid %0d: got %b expected 1", i, out_valid); end
        checks++;
        if (out_data !== mk_data(32'(i - 1))) begin errors++; $display("FAIL stream_data %0d: got %h expected %h", i, out_data, mk_data(32'(i - 1))); end
        checks++;
        if (out_instr !== mk_instr(32'(i - 1))) begin errors++; $display("FAIL stream_instr %0d: got %h expected %h", i, out_instr, mk_instr(32'(i - 1))); end
        $display("stream: out_data=%0h", out_data[31:0]);
      end
      cyc();
    end
  endtask

  task automatic test_back_pressure();
    vec_t tbl [7];
`ifdef PIPELINE_STAGE_SKID_EN
    tbl = '{
      '{1'b1, 8'hA, 1'b0, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b1, 8'hB, 1'b0, 1'b0, 1'b1, 8'hA, 1'b1, 2'd1},
      '{1'b1, 8'hC, 1'b0, 1'b0, 1'b1, 8'hA, 1'b0, 2'd2},
      '{1'b1, 8'hC, 1'b1, 1'b0, 1'b1, 8'hA, 1'b0, 2'd2},
      '{1'b1, 8'hC, 1'b1, 1'b0, 1'b1, 8'hB, 1'b1, 2'd1},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b1, 8'hC, 1'b1, 2'd1},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0}
    };
`else
    tbl = '{
      '{1'b1, 8'hA, 1'b0, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b1, 8'hB, 1'b0, 1'b0, 1'b1, 8'hA, 1'b0, 2'd1},
      '{1'b1, 8'hB, 1'b1, 1'b0, 1'b1, 8'hA, 1'b1, 2'd1},
      '{1'b1, 8'hC, 1'b1, 1'b0, 1'b1, 8'hB, 1'b1, 2'd1},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b1, 8'hC, 1'b1, 2'd1},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0}
    };
`endif
    for (int i = 0; i < 7; i++) begin
      logic [DATA_W-1:0] exp_d;
      logic [XLEN-1:0]   exp_i;
      offer(tbl[i].v, 32'(tbl[i].t), tbl[i].o, tbl[i].f);
      exp_d = tbl[i].ev ? mk_data(32'(tbl[i].et)) : '0;
      exp_i = tbl[i].ev ? mk_instr(32'(tbl[i].et)) : NOP;
      #2;
      checks++;
      if (out_valid !== tbl[i].ev) begin errors++; $display("FAIL bp_valid row %0d: got %b expected %b", i, out_valid, tbl[i].ev); end
      checks++;
      if (out_data !== exp_d) begin errors++; $display("FAIL bp_data row %0d: got %h expected %h", i, out_data, exp_d); end
      checks++;
      if (out_instr !== exp_i) begin errors++; $display("FAIL bp_instr row %0d: got %h expected %h", i, out_instr, exp_i); end
      checks++;
      if (in_ready !== tbl[i].er) begin errors++; $display("FAIL bp_ready row %0d: got %b expected %b", i, in_ready, tbl[i].er); end
      checks++;
      if (occupancy !== tbl[i].eo) begin errors++; $display("FAIL bp_occ row %0d: got %0d expected %0d", i, occupancy, tbl[i].eo); end
      $display("back_pressure row %0d: out_valid=%b out=%0h occ=%0d", i, out_valid, out_data[31:0], occupancy);
      cyc();
    end
  endtask

  task automatic test_flush_full();
    vec_t tbl [7];
`ifdef PIPELINE_STAGE_SKID_EN
    tbl = '{
      '{1'b1, 8'hA, 1'b0, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b1, 8'hB, 1'b0, 1'b0, 1'b1, 8'hA, 1'b1, 2'd1},
      '{1'b1, 8'hD, 1'b0, 1'b1, 1'b1, 8'hA, 1'b0, 2'd2},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b1, 8'hE, 1'b0, 1'b1, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0}
    };
`else
    tbl = '{
      '{1'b1, 8'hA, 1'b0, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b1, 8'hD, 1'b0, 1'b1, 1'b1, 8'hA, 1'b0, 2'd1},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b1, 8'hE, 1'b0, 1'b1, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0}
    };
`endif
    for (int i = 0; i < 7; i++) begin
      logic [DATA_W-1:0] exp_d;
      logic [XLEN-1:0]   exp_i;
      offer(tbl[i].v, 32'(tbl[i].t), tbl[i].o, tbl[i].f);
      exp_d = tbl[i].ev ? mk_data(32'(tbl[i].et)) : '0;
      exp_i = tbl[i].ev ? mk_instr(32'(tbl[i].et)) : NOP;
      #2;
      checks++;
      if (out_valid !== tbl[i].ev) begin errors++; $display("FAIL flush_valid row %0d: got %b expected %b", i, out_valid, tbl[i].ev); end
      checks++;
      if (out_data !== exp_d) begin errors++; $display("FAIL flush_data row %0d: got %h expected %h", i, out_data, exp_d); end
      checks++;
      if (out_instr !== exp_i) begin errors++; $display("FAIL flush_instr row %0d: got %h expected %h", i, out_instr, exp_i); end
      checks++;
      if (in_ready !== tbl[i].er) begin errors++; $display("FAIL flush_ready row %0d: got %b expected %b", i, in_ready, tbl[i].er); end
      checks++;
      if (occupancy !== tbl[i].eo) begin errors++; $display("FAIL flush_occ row %0d: got %0d expected %0d", i, occupancy, tbl[i].eo); end
      $display("flush row %0d: out_valid=%b instr=%h occ=%0d", i, out_valid, out_instr, occupancy);
      cyc();
    end
  endtask

  task automatic test_flush_consume();
    vec_t tbl [4];
    tbl = '{
      '{1'b1, 8'hA, 1'b0, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b0, 8'h0, 1'b1, 1'b1, 1'b1, 8'hA, 1'b1, 2'd1},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0},
      '{1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 2'd0}
    };
    for (int i = 0; i < 4; i++) begin
      logic [DATA_W-1:0] exp_d;
      logic [XLEN-1:0]   exp_i;
      offer(tbl[i].v, 32'(tbl[i].t), tbl[i].o, tbl[i].f);
      exp_d = tbl[i].ev ? mk_data(32'(tbl[i].et)) : '0;
      exp_i = tbl[i].ev ? mk_instr(32'(tbl[i].et)) : NOP;
      #2;
      checks++;
      if (out_valid !== tbl[i].ev) begin errors++; $display("FAIL fc_valid row %0d: got %b expected %b", i, out_valid, tbl[i].ev); end
      checks++;
      if (out_data !== exp_d) begin errors++; $display("FAIL fc_data row %0d: got %h expected %h", i, out_data, exp_d); end
      checks++;
      if (out_instr !== exp_i) begin errors++; $display("FAIL fc_instr row %0d: got %h expected %h", i, out_instr, exp_i); end
      checks++;
      if (in_ready !== tbl[i].er) begin errors++; $display("FAIL fc_ready row %0d: got %b expected %b", i, in_ready, tbl[i].er); end
      checks++;
      if (occupancy !== tbl[i].eo) begin errors++; $display("FAIL fc_occ row %0d: got %0d expected %0d", i, occupancy, tbl[i].eo); end
      $display("flush_consume row %0d: out_valid=%b out=%0h", i, out_valid, out_data[31:0]);
      cyc();
    end
  endtask

  task automatic test_random();
    logic [31:0] next_tag;
    logic        exp_rdy;
    logic        exp_vld;
    logic        acc;
    logic        cons;
    int          delivered;
    next_tag  = 32'h100;
    delivered = 0;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      offer(1'($urandom_range(0, 1)), next_tag, 1'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0);
      #2;
`ifdef PIPELINE_STAGE_SKID_EN
      exp_rdy = (q.size() < 2);
`else
      exp_rdy = (q.size() == 0) || out_ready;
`endif
      exp_vld = (q.size() != 0);
      checks++;
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", c, in_ready, exp_rdy); end
      checks++;
      if (out_valid !== exp_vld) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", c, out_valid, exp_vld); end
      checks++;
      if (occupancy !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ cyc %0d: got %0d expected %0d", c, occupancy, q.size()); end
      if (exp_vld) begin
        checks++;
        if (out_data !== mk_data(q[0])) begin errors++; $display("FAIL rnd_data cyc %0d: got %h expected %h", c, out_data, mk_data(q[0])); end
        checks++;
        if (out_instr !== mk_instr(q[0])) begin errors++; $display("FAIL rnd_instr cyc %0d: got %h expected %h", c, out_instr, mk_instr(q[0])); end
      end else begin
        checks++;
        if (out_data !== '0 || out_instr !== NOP) begin errors++; $display("FAIL rnd_bubble cyc %0d: got %h/%h expected 0/%h", c, out_data, out_instr, NOP); end
      end
      acc  = in_valid & exp_rdy & ~flush;
      cons = exp_vld & out_ready;
      if (cons) begin
        void'(q.pop_front());
        delivered++;
      end
      if (flush) q.delete();
      else if (acc) q.push_back(next_tag);
      if (acc) next_tag++;
      cyc();
    end
    $display("random: %0d entries delivered", delivered);
    offer(1'b0, 32'h0, 1'b1, 1'b1);
    cyc();
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    cyc();
  endtask

  initial begin
    reset_n = 1'b0;
    offer(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    cyc();
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush_full();
    test_flush_consume();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
